// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: FSM states, ALU status
// encoding and the one-hot ALU input-select codes.
package alu_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_EMIT  = 3'd4,
    S_FIN   = 3'd5
  } state_e;

  localparam logic [1:0] ST_HOLD     = 2'b10;

  localparam logic [2:0] SEL_PERSIST = 3'b100;
  localparam logic [2:0] SEL_LOAD    = 3'b010;
  localparam logic [2:0] SEL_RESET   = 3'b001;
  localparam logic [2:0] SEL_NONE    = 3'b000;

endpackage

// File: rtl/alu_op_sequencer_prio_pick.sv
// Priority picker: index of the highest set bit of a mask, with a flag when
// the mask is empty.
module prio_pick #(
  parameter int W = 7
) (
  input  logic [W-1:0] mask_i,
  output logic [2:0]   idx_o,
  output logic         none_o
);

  // Ascending scan so the last (highest) set bit wins.
  always_comb begin
    idx_o  = 3'd0;
    none_o = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (mask_i[i]) begin
        idx_o  = 3'(i);
        none_o = 1'b0;
      end else begin
        idx_o  = idx_o;
        none_o = none_o;
      end
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Runs each selected ALU operation in turn, highest mask bit first, and hands
// every result out through a valid/ready port before pulsing done.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WAIT_MAX = 16,
  parameter int OP_W     = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [7:0]      op_a,
  input  logic [7:0]      op_b,
  input  logic [OP_W-1:0] op_mask,
  output logic            busy,
  output logic            alu_on,
  output logic [2:0]      alu_in_sel,
  output logic [7:0]      alu_num1,
  output logic [7:0]      alu_num2,
  output logic [OP_W-1:0] alu_out_sel,
  input  logic [7:0]      alu_out,
  input  logic [1:0]      alu_state,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [7:0]      res_data,
  output logic [2:0]      res_op,
  output logic            res_err,
  output logic            done
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [OP_W-1:0] ONE = {{(OP_W-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [7:0]      a_q, a_d, b_q, b_d;
  logic [OP_W-1:0] mask_q, mask_d;
  logic [2:0]      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      data_q, data_d;
  logic            err_q, err_d;

  logic            busy_q, busy_d, alu_on_q, alu_on_d;
  logic [2:0]      in_sel_q, in_sel_d;
  logic [OP_W-1:0] out_sel_q, out_sel_d;
  logic            valid_q, valid_d, done_q, done_d;

  logic [2:0]      pick_idx_s;
  logic            pick_none_s;

  prio_pick #(.W(OP_W)) u_pick (
    .mask_i (mask_q),
    .idx_o  (pick_idx_s),
    .none_o (pick_none_s)
  );

  // Sequencer next-state and datapath capture.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mask_d  = mask_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          mask_d  = op_mask;
          state_d = (op_mask != '0) ? S_CLEAR : S_FIN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        op_d    = pick_idx_s;
        cnt_d   = '0;
        state_d = pick_none_s ? S_FIN : S_LOAD;
      end
      S_LOAD: state_d = S_WAIT;
      S_WAIT: begin
        if (alu_state == ST_HOLD) begin
          data_d  = alu_out;
          err_d   = 1'b0;
          state_d = S_EMIT;
        end else if (cnt_q == CW'(WAIT_MAX - 1)) begin
          data_d  = 8'h00;
          err_d   = 1'b1;
          state_d = S_EMIT;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_EMIT: begin
        if (res_ready) begin
          mask_d  = mask_q & ~(ONE << op_q);
          state_d = (mask_d != '0) ? S_CLEAR : S_FIN;
        end else begin
          state_d = S_EMIT;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    busy_d    = (state_d != S_IDLE);
    alu_on_d  = (state_d == S_CLEAR) || (state_d == S_LOAD) || (state_d == S_WAIT);
    valid_d   = (state_d == S_EMIT);
    done_d    = (state_d == S_FIN);
    out_sel_d = '0;
    case (state_d)
      S_CLEAR: in_sel_d = SEL_RESET;
      S_LOAD:  in_sel_d = SEL_LOAD;
      S_WAIT:  in_sel_d = SEL_PERSIST;
      default: in_sel_d = SEL_NONE;
    endcase
    if ((state_d == S_LOAD) || (state_d == S_WAIT)) begin
      out_sel_d = ONE << op_d;
    end else begin
      out_sel_d = '0;
    end
  end

  // State, latched operands and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      mask_q    <= '0;
      op_q      <= 3'd0;
      cnt_q     <= '0;
      data_q    <= 8'h00;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      alu_on_q  <= 1'b0;
      in_sel_q  <= SEL_NONE;
      out_sel_q <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mask_q    <= mask_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      alu_on_q  <= alu_on_d;
      in_sel_q  <= in_sel_d;
      out_sel_q <= out_sel_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign busy        = busy_q;
  assign alu_on      = alu_on_q;
  assign alu_in_sel  = in_sel_q;
  assign alu_num1    = a_q;
  assign alu_num2    = b_q;
  assign alu_out_sel = out_sel_q;
  assign res_valid   = valid_q;
  assign res_data    = data_q;
  assign res_op      = op_q;
  assign res_err     = err_q;
  assign done        = done_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small behavioural ALU that
// reports ST_HOLD a programmable number of cycles after LOAD.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, res_ready;
  logic [7:0] op_a, op_b;
  logic [6:0] op_mask;
  logic       busy, alu_on, res_valid, res_err, done;
  logic [2:0] alu_in_sel, res_op;
  logic [7:0] alu_num1, alu_num2, alu_out, res_data;
  logic [6:0] alu_out_sel;
  logic [1:0] alu_state;

  int tests = 0;
  int fails = 0;
  int hold_lat = 1;
  bit never_hold = 1'b0;
  int alu_cnt;
  int done_cnt = 0;
  int valid_cnt = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WAIT_MAX(16), .OP_W(7)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .op_mask(op_mask), .busy(busy), .alu_on(alu_on), .alu_in_sel(alu_in_sel),
    .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_out_sel(alu_out_sel),
    .alu_out(alu_out), .alu_state(alu_state), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_op(res_op),
    .res_err(res_err), .done(done)
  );

  // ALU model: counts cycles since the LOAD edge, HOLD once hold_lat is reached.
  always @(posedge clk or posedge rst) begin
    if (rst) alu_cnt <= 0;
    else if (alu_in_sel == 3'b001) alu_cnt <= 0;
    else if (alu_in_sel == 3'b010) alu_cnt <= 1;
    else if (alu_cnt > 0 && alu_cnt < hold_lat) alu_cnt <= alu_cnt + 1;
  end

  assign alu_state = (!never_hold && alu_cnt >= hold_lat) ? 2'b10 : 2'b01;
  assign alu_out = alu_out_sel[6] ? (alu_num1 + alu_num2) :
                   alu_out_sel[2] ? (alu_num1 | alu_num2) : (alu_num2 - alu_num1);

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (res_valid) valid_cnt <= valid_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Entered at the negedge of a CLEAR cycle; leaves at the negedge after the handshake.
  task automatic run_op(input logic [2:0] exp_op, input logic [7:0] exp_data,
                        input logic exp_err, input int exp_wait, input int stall);
    int n;
    logic [6:0] sel;
    sel = 7'b0000001 << exp_op;
    chk("clear_sel", alu_in_sel, 3'b001);
    chk("clear_on", alu_on, 1'b1);
    tick();
    chk("load_sel", alu_in_sel, 3'b010);
    chk("load_outsel", alu_out_sel, sel);
    tick();
    chk("wait_sel", alu_in_sel, 3'b100);
    n = 0;
    while (!res_valid && n < 40) begin
      tick();
      n++;
    end
    chk("wait_cycles", n, exp_wait);
    chk("valid", res_valid, 1'b1);
    chk("res_data", res_data, exp_data);
    chk("res_op", res_op, exp_op);
    chk("res_err", res_err, exp_err);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_valid", res_valid, 1'b1);
      chk("stall_data", res_data, exp_data);
      chk("stall_op", res_op, exp_op);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("post_hs_valid", res_valid, 1'b0);
  endtask

  task automatic go(input logic [6:0] m, input logic [7:0] a, input logic [7:0] b);
    op_mask = m; op_a = a; op_b = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n, d0, v0;
    rst = 1'b1; start = 1'b0; res_ready = 1'b0;
    op_a = 8'h00; op_b = 8'h00; op_mask = 7'h00;
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_insel", alu_in_sel, 3'b000);
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_on", alu_on, 1'b0);
    chk("rst_num1", alu_num1, 8'h00);
    rst = 1'b0;
    tick();

    // Single op, ALU holds 2 cycles after LOAD
    hold_lat = 2;
    go(7'b1000000, 8'h57, 8'h1A);
    chk("t1_busy", busy, 1'b1);
    chk("t1_num1", alu_num1, 8'h57);
    chk("t1_num2", alu_num2, 8'h1A);
    d0 = done_cnt;
    run_op(3'd6, 8'h71, 1'b0, 2, 0);
    chk("t1_done", done, 1'b1);
    tick();
    chk("t1_done_pulse", done, 1'b0);
    chk("t1_idle", busy, 1'b0);
    chk("t1_done_cnt", done_cnt - d0, 1);

    // Empty mask: straight to FIN
    v0 = valid_cnt; d0 = done_cnt;
    op_mask = 7'h00; start = 1'b1;
    n = 0;
    tick();
    start = 1'b0;
    n = 1;
    while (!done && n < 5) begin tick(); n++; end
    chk("t2_done_seen", done, 1'b1);
    chk("t2_done_lat_ok", (n >= 1 && n <= 2), 1'b1);
    tick();
    chk("t2_done_pulse", done, 1'b0);
    chk("t2_no_valid", valid_cnt - v0, 0);
    chk("t2_done_cnt", done_cnt - d0, 1);

    // Two ops with stalled consumer; minimum latency (hold in first WAIT)
    hold_lat = 1;
    go(7'b0000101, 8'h02, 8'h04);
    run_op(3'd2, 8'h06, 1'b0, 1, 3);
    run_op(3'd0, 8'h02, 1'b0, 1, 3);
    chk("t3_done", done, 1'b1);
    tick();

    // Timeout on first op, then recovery on the next
    never_hold = 1'b1;
    go(7'b0000011, 8'h10, 8'h30);
    run_op(3'd1, 8'h00, 1'b1, 16, 0);
    never_hold = 1'b0;
    run_op(3'd0, 8'h20, 1'b0, 1, 0);
    chk("t4_done", done, 1'b1);
    tick();

    // Reset during WAIT of the second op
    d0 = done_cnt;
    go(7'b1000100, 8'h03, 8'h05);
    run_op(3'd6, 8'h08, 1'b0, 1, 0);
    never_hold = 1'b1;
    tick(); tick();
    chk("t5_in_wait", alu_in_sel, 3'b100);
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_insel", alu_in_sel, 3'b000);
    chk("t5_rst_outsel", alu_out_sel, 7'h00);
    chk("t5_rst_num1", alu_num1, 8'h00);
    chk("t5_rst_on", alu_on, 1'b0);
    tick();
    rst = 1'b0;
    never_hold = 1'b0;
    tick();
    chk("t5_no_done", done_cnt - d0, 0);
    go(7'b0000001, 8'h09, 8'h0C);
    run_op(3'd0, 8'h03, 1'b0, 1, 0);
    chk("t5_done", done, 1'b1);
    tick();

    // Start held while busy with other inputs is ignored
    hold_lat = 2;
    v0 = valid_cnt; d0 = done_cnt;
    go(7'b0100000, 8'h20, 8'h50);
    op_mask = 7'h7F; op_a = 8'hFF; op_b = 8'hFF; start = 1'b1;
    run_op(3'd5, 8'h30, 1'b0, 2, 1);
    start = 1'b0;
    chk("t6_done", done, 1'b1);
    chk("t6_num1", alu_num1, 8'h20);
    tick(); tick(); tick();
    chk("t6_idle", busy, 1'b0);
    chk("t6_valid_cnt", valid_cnt - v0, 2);
    chk("t6_done_cnt", done_cnt - d0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
